// File: rtl/len5_pkg.sv
// Shared core-wide widths for the LEN5 integer datapath.
// Pure constants, no logic.
// Consumed by the commit and register-file blocks.
package len5_pkg;
  localparam int XLEN        = 32;
  localparam int REG_IDX_LEN = 5;
endpackage

// File: rtl/int_rf_commit_if.sv
// ROB-head input side and integer register file write side of the commit writer.
// No logic; the commit writer is the slave, the ROB/RF environment is the master.
// rob_ready_o and rf_ready_i carry the valid/ready backpressure on each side.
interface int_rf_commit_if;
  import len5_pkg::*;

  logic                   rob_valid_i;
  logic                   rob_ready_o;
  logic [REG_IDX_LEN-1:0] rob_rd_idx_i;
  logic [XLEN-1:0]        rob_rd_value_i;
  logic                   rob_rd_we_i;
  logic                   rob_except_i;

  logic                   rf_valid_o;
  logic                   rf_ready_i;
  logic [REG_IDX_LEN-1:0] rf_rd_idx_o;
  logic [XLEN-1:0]        rf_rd_value_o;

  modport slave (
    input  rob_valid_i, rob_rd_idx_i, rob_rd_value_i, rob_rd_we_i, rob_except_i, rf_ready_i,
    output rob_ready_o, rf_valid_o, rf_rd_idx_o, rf_rd_value_o
  );

  modport master (
    output rob_valid_i, rob_rd_idx_i, rob_rd_value_i, rob_rd_we_i, rob_except_i, rf_ready_i,
    input  rob_ready_o, rf_valid_o, rf_rd_idx_o, rf_rd_value_o
  );
endinterface

// File: rtl/int_rf_commit.sv
// Commit-side writer: queues retiring integer results and writes them to the int RF in order; counts retirements.
// Latency: accepted write appears on rf_valid_o one cycle later (zero cycles with INT_RF_COMMIT_BYPASS_EN and empty FIFO).
// Backpressure: rob_ready_o drops when the FIFO is full or an exception is draining; no combinational path from rf_ready_i.
module int_rf_commit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  int_rf_commit_if.slave   bus,
  output logic             except_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             busy_o
);
  import len5_pkg::*;

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, EXCEPT} state_t;

  typedef struct packed {
    logic [REG_IDX_LEN-1:0] idx;
    logic [XLEN-1:0]        value;
  } wr_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  wr_t              mem_q [DEPTH];

  logic full, empty, accept, push_cand, push, pop, bypass;
  wr_t  head;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Handshake decode: acceptance, push/pop qualification and RF-side outputs
  always_comb begin
    bus.rob_ready_o = (state_q == RUN) && !full && !rst_i;
    accept    = bus.rob_valid_i && bus.rob_ready_o;
    push_cand = accept && bus.rob_rd_we_i && (bus.rob_rd_idx_i != '0) && !bus.rob_except_i;
    pop       = !empty && bus.rf_ready_i;
`ifdef INT_RF_COMMIT_BYPASS_EN
    // An empty FIFO lets the accepted write go straight out; it is only stored if the RF stalls.
    bypass = empty && push_cand;
    push   = push_cand && !(bypass && bus.rf_ready_i);
`else
    bypass = 1'b0;
    push   = push_cand;
`endif
    bus.rf_valid_o    = !empty || bypass;
    bus.rf_rd_idx_o   = '0;
    bus.rf_rd_value_o = '0;
    if (bypass) begin
      bus.rf_rd_idx_o   = bus.rob_rd_idx_i;
      bus.rf_rd_value_o = bus.rob_rd_value_i;
    end else if (!empty) begin
      bus.rf_rd_idx_o   = head.idx;
      bus.rf_rd_value_o = head.value;
    end
  end

  // Next pointers, occupancy and retired-instruction count
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    instret_d = (accept && !bus.rob_except_i) ? instret_q + 1'b1 : instret_q;
  end

  // Datapath registers; reset discards queued writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      instret_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      instret_q <= instret_d;
    end
  end

  // FIFO storage: written on push, deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{idx: bus.rob_rd_idx_i, value: bus.rob_rd_value_i};
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: exception accept starts a drain; leave drain once empty and idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && bus.rob_except_i) state_d = DRAIN;
      DRAIN:   if (empty && !push && !pop)     state_d = EXCEPT;
      EXCEPT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    except_o  = (state_q == EXCEPT);
    busy_o    = (state_q != RUN) || !empty;
    instret_o = instret_q;
  end

endmodule

// File: tb/tb_int_rf_commit.sv
// Randomized + directed bench for int_rf_commit with a queue-based reference model and decoupled RF-side monitor.
// Build with +define+INT_RF_COMMIT_BYPASS_EN to exercise the zero-latency path.
// Expected writes are queued at acceptance and popped by the monitor when the RF handshake fires.
module tb_int_rf_commit;
  import len5_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 64;
`ifdef INT_RF_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum int {M_RUN, M_DRAIN, M_EXCEPT} mstate_t;
  typedef struct {
    logic [REG_IDX_LEN-1:0] idx;
    logic [XLEN-1:0]        val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             except_o;
  logic [CNT_W-1:0] instret_o;
  logic             busy_o;

  int_rf_commit_if bus ();

  int_rf_commit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .bus      (bus),
    .except_o (except_o),
    .instret_o(instret_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t             scb[$];
  mstate_t          mstate = M_RUN;
  logic [CNT_W-1:0] m_instret = '0;
  logic             exp_vld = 1'b0;
  logic             mon_rst = 1'b1;
  int               stim_cyc = 0;
  int               n_written = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive after the rising edge, check and advance the model at the falling edge.
  task automatic cycle(input logic v, input logic [REG_IDX_LEN-1:0] idx, input logic [XLEN-1:0] val,
                       input logic we, input logic exc, input logic rfr, input logic rst,
                       output logic acc);
    logic exp_ready;
    int   sz;
    bit   pushed;
    @(posedge clk);
    #1;
    rst_i              = rst;
    bus.rob_valid_i    = v;
    bus.rob_rd_idx_i   = idx;
    bus.rob_rd_value_i = val;
    bus.rob_rd_we_i    = we;
    bus.rob_except_i   = exc;
    bus.rf_ready_i     = rfr;
    @(negedge clk);
    sz        = scb.size();
    exp_ready = !rst && (mstate == M_RUN) && (sz < DEPTH);
    chk("rob_ready", bus.rob_ready_o, exp_ready);
    chk("except", except_o, mstate == M_EXCEPT);
    chk("instret", instret_o, m_instret);
    chk("busy", busy_o, (mstate != M_RUN) || (sz != 0));
    acc    = v && exp_ready;
    pushed = 0;
    if (rst) begin
      scb.delete();
      mstate    = M_RUN;
      m_instret = '0;
    end else begin
      case (mstate)
        M_RUN:    if (acc && exc) mstate = M_DRAIN;
        M_DRAIN:  if (sz == 0) mstate = M_EXCEPT;
        default:  mstate = M_RUN;
      endcase
      if (acc && !exc) begin
        m_instret = m_instret + 1;
        if (we && idx != 0) begin
          scb.push_back('{idx: idx, val: val});
          pushed = 1;
        end
      end
    end
    exp_vld = (sz != 0) || (BYP && pushed && sz == 0);
    mon_rst = rst;
    stim_cyc++;
  endtask

  // Monitor: consumes RF writes as the DUT presents them and compares against the scoreboard.
  initial begin
    int seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (stim_cyc != seen) begin
        seen = stim_cyc;
        if (!mon_rst) begin
          chk("rf_valid", bus.rf_valid_o, exp_vld);
          if (bus.rf_valid_o && bus.rf_ready_i) begin
            if (scb.size() == 0) begin
              errors++;
              $display("FAIL rf_write_unexpected: got idx %0d, expected no write", bus.rf_rd_idx_o);
            end else begin
              e = scb.pop_front();
              chk("rf_idx", bus.rf_rd_idx_o, e.idx);
              chk("rf_value", bus.rf_rd_value_o, e.val);
              n_written++;
            end
          end else if (!bus.rf_valid_o) begin
            chk("rf_idx_idle", bus.rf_rd_idx_o, 0);
            chk("rf_value_idle", bus.rf_rd_value_o, 0);
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    int   budget;
    logic rfr;
    int   prob;

    rst_i = 1'b1;
    bus.rob_valid_i = 0; bus.rob_rd_idx_i = 0; bus.rob_rd_value_i = 0;
    bus.rob_rd_we_i = 0; bus.rob_except_i = 0; bus.rf_ready_i = 0;

    // Reset, then the idle state right after it
    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("reset_instret", instret_o, 0);

    // Plain write, then x0 and non-writing entries
    cycle(1, 5, 32'hDEADBEEF, 1, 0, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    cycle(1, 0, 32'h11, 1, 0, 1, 0, acc);
    cycle(1, 3, 32'h22, 0, 0, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("instret_after_nowrite", instret_o, 3);

    // Fill with RF stalled, then release
    for (int i = 1; i <= 4; i++) cycle(1, i[4:0], 32'h100 + i, 1, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 5, 32'h105, 1, 0, 0, 0, acc);
      chk("full_blocks", acc, 0);
    end
    budget = 0;
    do begin
      cycle(1, 5, 32'h105, 1, 0, 1, 0, acc);
      budget++;
    end while (!acc && budget < 20);
    chk("idx5_accepted", acc, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("fill_drained", scb.size(), 0);

    // Exception behind two queued writes
    cycle(1, 9, 32'hA9, 1, 0, 0, 0, acc);
    cycle(1, 10, 32'hAA, 1, 0, 0, 0, acc);
    cycle(1, 11, 32'hAB, 1, 1, 1, 0, acc);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1, 0, acc);

    // Reset with writes pending
    for (int i = 0; i < 3; i++) cycle(1, 5'(12 + i), 32'hC0 + i, 1, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, acc);
    chk("rst_clears_busy", busy_o, 0);
    chk("rst_clears_valid", bus.rf_valid_o, 0);

    // Single write into an empty FIFO with the RF ready (same-cycle in bypass build)
    cycle(1, 7, 32'h1234, 1, 0, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);

    // Randomized traffic with bursty RF readiness and occasional exceptions/resets
    prob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0) prob = $urandom_range(0, 100);
      rfr = ($urandom_range(0, 99) < prob);
      cycle($urandom_range(0, 9) < 7,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 39) == 0,
            rfr,
            $urandom_range(0, 299) == 0,
            acc);
    end

    // Drain everything outstanding
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0, 1, 0, acc);
    chk("final_drained", scb.size(), 0);
    chk("final_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_rf_commit.md
Name: int_rf_commit

Overview:
Commit-side writer for the integer register file write port. It accepts retiring instructions from the ROB head and buffers their integer results in a small in-order FIFO. It drives the register file write handshake (valid/ready with rd index and value) and keeps the retired-instruction counter. On a retiring exception it stops accepting new entries, drains every write queued before the exception, then raises a single-cycle exception pulse.

Parameters:
DEPTH, 4, write FIFO entries; power of 2, >= 2
CNT_W, 64, width of retired-instruction counter
(XLEN and REG_IDX_LEN come from len5_pkg)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
rob_valid_i  in  1  ROB head entry valid
rob_ready_o  out  1  block accepts ROB head entry
rob_rd_idx_i  in  REG_IDX_LEN  destination register index
rob_rd_value_i  in  XLEN  result value
rob_rd_we_i  in  1  instruction writes rd
rob_except_i  in  1  entry carries an exception
rf_valid_o  out  1  write request to the int RF
rf_ready_i  in  1  int RF accepts the write
rf_rd_idx_o  out  REG_IDX_LEN  write index
rf_rd_value_o  out  XLEN  write data
except_o  out  1  exception pulse, after drain
instret_o  out  CNT_W  retired-instruction count
busy_o  out  1  FIFO non-empty or FSM not in RUN

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Accept: an entry is accepted on rob_valid_i && rob_ready_o.
- rob_ready_o = (state==RUN) && !full && !rst_i.
  - It has no combinational path from rf_ready_i.
  - A full FIFO therefore blocks acceptance even in a cycle where a pop occurs.
- Push: push {idx, value} only if the accepted entry has rob_rd_we_i=1, rob_rd_idx_i!=0 and rob_except_i=0.
  - Writes to x0 and non-writing entries retire without a push.
- Pop: rf_valid_o = !empty. rf_rd_idx_o and rf_rd_value_o show the FIFO head and are forced to 0 when empty.
  - Pop occurs on rf_valid_o && rf_ready_i.
  - Writes leave strictly in acceptance order.
- Latency: an entry accepted in cycle t appears on rf_valid_o in cycle t+1.
- Simultaneous push and pop: allowed whenever not full; occupancy count is unchanged.
- Pointers: wrap modulo DEPTH. Occupancy count runs 0..DEPTH, so full and empty are distinguished by the count.
- instret_o: +1 per accepted entry with rob_except_i=0, whether or not it writes rd.
  - Wraps from 2^CNT_W-1 to 0.
  - Registered output; the new value is visible the cycle after acceptance.
- FSM states RUN, DRAIN, EXCEPT:
  - RUN -> DRAIN on accepting an entry with rob_except_i=1. Nothing is pushed and instret_o is not incremented.
  - DRAIN: rob_ready_o=0. Go to EXCEPT in the first DRAIN cycle in which the count is 0 with no push or pop in that cycle. Minimum one DRAIN cycle.
  - EXCEPT: except_o=1 for exactly one cycle, rob_ready_o=0, then go to RUN.
  - With an empty FIFO at accept t: DRAIN at t+1, except_o at t+2, rob_ready_o=1 again at t+3.
- busy_o = (state!=RUN) || !empty.
- Reset values: state RUN, count/pointers 0, instret_o 0, rf_valid_o 0, except_o 0, rf data outputs 0.
  - rob_ready_o is 0 while rst_i=1 and 1 in the first cycle after reset.
- Reset mid-operation: all queued writes are discarded and no except_o is issued. FIFO storage itself is not reset.
- rf_ready_i held low: the FIFO fills, rob_ready_o drops, and the block holds indefinitely with no loss.

Optional Feature:
INT_RF_COMMIT_BYPASS_EN
- Defined: when state==RUN, the FIFO is empty and the accepted entry would be pushed, rf_valid_o/rf_rd_idx_o/rf_rd_value_o are driven combinationally from the rob_* inputs (zero latency).
  - If rf_ready_i=1 in that cycle, the entry is not stored.
  - Otherwise it is pushed and presented again from the FIFO next cycle.
- Undefined: no bypass; fixed 1-cycle latency as above.

Test Plan:
1. After reset, rf_ready_i=1; accept idx=5, value=0xDEADBEEF, we=1 -> rf_valid_o=1 with idx 5, value 0xDEADBEEF next cycle, for one cycle; instret_o=1.
2. Accept idx=0 we=1, then idx=3 we=0 -> rf_valid_o never asserts; instret_o=2.
3. DEPTH=4, rf_ready_i=0; offer 5 writing entries (idx 1..5) -> 4 accepted, rob_ready_o=0. Raise rf_ready_i -> writes idx 1,2,3,4 in consecutive cycles; idx 5 accepted, then written.
4. rf_ready_i=1, two writes queued, then accept an entry with rob_except_i=1 -> both writes complete first. except_o is high exactly one cycle after the drain; rob_ready_o=0 from the cycle after the exception accept until the cycle after except_o; instret_o=2.
5. Three writes queued, rf_ready_i=0; assert rst_i one cycle -> next cycle rf_valid_o=0, instret_o=0, busy_o=0, except_o stays 0.
6. With INT_RF_COMMIT_BYPASS_EN, empty FIFO, rf_ready_i=1; accept idx=7, value=0x1234 -> rf_valid_o=1 with idx 7 in the same cycle; FIFO stays empty.
